// File: rtl/jam_cost_table.sv
// jam_cost_table: 8x8 cost memory loaded row-major over a valid/ready stream, then
// answering {W,J} lookups. Define JAM_COST_ACCESS_CNT_EN to add the rd_count lookup counter.
module jam_cost_table #(
  parameter int RD_LAT = 0,
  parameter int COST_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              reload,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost
`ifdef JAM_COST_ACCESS_CNT_EN
  ,
  output logic [15:0]       rd_count
`endif
);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t            state_reg, state_next;
  logic [5:0]        idx_reg, idx_next;
  logic              wr_en;
  logic [5:0]        addr;
  logic [COST_W-1:0] mem [0:63];

  assign addr = {W, J};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= EMPTY;
      idx_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // reload takes priority over any transfer presented in the same cycle
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wr_en      = 1'b0;
    load_ready = 1'b1;
    load_done  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (reload) begin
          idx_next = 6'd0;
        end else if (load_valid) begin
          wr_en      = 1'b1;
          idx_next   = idx_reg + 6'd1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (reload) begin
          idx_next   = 6'd0;
          state_next = EMPTY;
        end else if (load_valid) begin
          wr_en = 1'b1;
          if (idx_reg == 6'd63) begin
            idx_next   = 6'd0;
            state_next = READY;
          end else begin
            idx_next = idx_reg + 6'd1;
          end
        end
      end
      READY: begin
        load_ready = 1'b0;
        load_done  = 1'b1;
        if (reload) begin
          idx_next   = 6'd0;
          state_next = EMPTY;
        end
      end
      default: begin
        idx_next   = 6'd0;
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[idx_reg] <= load_data;
  end

  generate
    if (RD_LAT == 0) begin : g_rd_comb
      assign Cost = (state_reg == READY) ? mem[addr] : '0;
    end else begin : g_rd_reg
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) Cost <= '0;
        else     Cost <= (state_reg == READY) ? mem[addr] : '0;
      end
    end
  endgenerate

`ifdef JAM_COST_ACCESS_CNT_EN
  logic [5:0]  prev_addr_reg;
  logic        was_ready_reg;
  logic [15:0] cnt_reg;

  // a READY cycle counts when it is the first one or the address moved
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_addr_reg <= 6'd0;
      was_ready_reg <= 1'b0;
      cnt_reg       <= 16'd0;
    end else begin
      prev_addr_reg <= addr;
      was_ready_reg <= (state_reg == READY);
      if (reload)
        cnt_reg <= 16'd0;
      else if ((state_reg == READY) && (!was_ready_reg || addr != prev_addr_reg) &&
               cnt_reg != 16'hFFFF)
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign rd_count = cnt_reg;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table: one combinational-read and one registered-read
// instance share stimulus; each scenario task checks its own expectations.
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST;
  logic       load_valid;
  logic       reload;
  logic [6:0] load_data;
  logic [2:0] W, J;
  logic       ready0, done0, ready1, done1;
  logic [6:0] cost0, cost1;
`ifdef JAM_COST_ACCESS_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  jam_cost_table #(.RD_LAT(0), .COST_W(7)) u0 (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready0), .load_done(done0), .reload(reload), .W(W), .J(J),
    .Cost(cost0)
`ifdef JAM_COST_ACCESS_CNT_EN
    , .rd_count(cnt0)
`endif
  );

  jam_cost_table #(.RD_LAT(1), .COST_W(7)) u1 (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready1), .load_done(done1), .reload(reload), .W(W), .J(J),
    .Cost(cost1)
`ifdef JAM_COST_ACCESS_CNT_EN
    , .rd_count(cnt1)
`endif
  );

  function automatic logic [6:0] val(input int kind, input int a);
    case (kind)
      0:       return 7'(a % 101);
      1:       return 7'd100;
      default: return 7'((a * 3 + 7) & 127);
    endcase
  endfunction

  // Streams words first..first+count-1; inputs change on the falling edge.
  task automatic stream(input int kind, input bit toggle, input int first, input int count,
                        output int rdy, output int cyc);
    int n;
    n   = first;
    rdy = 0;
    cyc = 0;
    while (n < first + count && cyc < 400) begin
      @(negedge CLK);
      total++;
      if (done0 !== 1'b0) begin
        bad++;
        $display("FAIL early_done word=%0d got=%b want=0", n, done0);
      end
      load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      load_data  = val(kind, n);
      if (ready0) rdy++;
      if (load_valid && ready0) n++;
      cyc++;
    end
    @(negedge CLK);
    load_valid = 1'b0;
    $display("stream kind=%0d toggle=%0d words=%0d cycles=%0d ready_cycles=%0d",
             kind, toggle, n - first, cyc, rdy);
  endtask

  task automatic check_done(input string name);
    total++;
    if (done0 !== 1'b1 || ready0 !== 1'b0 || done1 !== 1'b1) begin
      bad++;
      $display("FAIL %s done0=%b ready0=%b done1=%b want 1/0/1", name, done0, ready0, done1);
    end
  endtask

  task automatic pulse_reload(input bit with_valid);
    @(negedge CLK);
    reload     = 1'b1;
    load_valid = with_valid;
    load_data  = 7'd55;
    @(negedge CLK);
    reload     = 1'b0;
    load_valid = 1'b0;
  endtask

  // Address sweep: comb Cost checked same cycle, registered Cost one cycle later.
  task automatic sweep(input int kind, input string name);
    logic [5:0] ad;
    int errs;
    errs = 0;
    for (int n = 0; n <= 64; n++) begin
      @(negedge CLK);
      if (n > 0) begin
        total++;
        if (cost1 !== val(kind, n - 1)) begin
          bad++;
          errs++;
          $display("FAIL %s_lat1 addr=%0d got=%0d want=%0d", name, n - 1, cost1, val(kind, n - 1));
        end
      end
      if (n < 64) begin
        ad = 6'(n);
        W  = ad[5:3];
        J  = ad[2:0];
        #1;
        total++;
        if (cost0 !== val(kind, n)) begin
          bad++;
          errs++;
          $display("FAIL %s_lat0 addr=%0d got=%0d want=%0d", name, n, cost0, val(kind, n));
        end
      end
    end
    $display("sweep %s kind=%0d errors=%0d", name, kind, errs);
  endtask

  task automatic test_reset;
    RST = 1'b1; load_valid = 1'b0; reload = 1'b0; load_data = '0; W = '0; J = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    total++;
    if (ready0 !== 1'b1 || done0 !== 1'b0 || ready1 !== 1'b1 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags ready=%b/%b done=%b/%b want 1/1 0/0", ready0, ready1, done0, done1);
    end
    total++;
    if (cost0 !== 7'd0 || cost1 !== 7'd0) begin
      bad++;
      $display("FAIL reset_cost got=%0d/%0d want=0", cost0, cost1);
    end
`ifdef JAM_COST_ACCESS_CNT_EN
    total++;
    if (cnt0 !== 16'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", cnt0);
    end
`endif
    $display("reset ready=%b done=%b cost=%0d", ready0, done0, cost0);
  endtask

  task automatic test_stream;
    int rdy, cyc;
    stream(0, 1'b0, 0, 64, rdy, cyc);
    total++;
    if (rdy != 64) begin
      bad++;
      $display("FAIL ready_cycles got=%0d want=64", rdy);
    end
    check_done("stream_done");
    W = 3'd3; J = 3'd5; #1;
    total++;
    if (cost0 !== 7'd29) begin
      bad++;
      $display("FAIL lookup_3_5 got=%0d want=29", cost0);
    end
    W = 3'd7; J = 3'd7; #1;
    total++;
    if (cost0 !== 7'd63) begin
      bad++;
      $display("FAIL lookup_7_7 got=%0d want=63", cost0);
    end
    $display("lookup 7,7 cost=%0d", cost0);
  endtask

  task automatic test_lookup_during_load;
    int rdy, cyc;
    pulse_reload(1'b0);
    stream(0, 1'b0, 0, 10, rdy, cyc);
    W = 3'd0; J = 3'd2; #1;
    total++;
    if (cost0 !== 7'd0) begin
      bad++;
      $display("FAIL load_lookup_lat0 got=%0d want=0", cost0);
    end
    @(negedge CLK);
    total++;
    if (cost1 !== 7'd0) begin
      bad++;
      $display("FAIL load_lookup_lat1 got=%0d want=0", cost1);
    end
    stream(0, 1'b0, 10, 54, rdy, cyc);
    check_done("finish_done");
    #1;
    total++;
    if (cost0 !== 7'd2) begin
      bad++;
      $display("FAIL finish_lookup got=%0d want=2", cost0);
    end
    $display("lookup_during_load final cost=%0d", cost0);
  endtask

  task automatic test_reload_same_cycle;
    int rdy, cyc;
    pulse_reload(1'b1);
    total++;
    if (done0 !== 1'b0 || ready0 !== 1'b1) begin
      bad++;
      $display("FAIL reload_empty done=%b ready=%b want 0/1", done0, ready0);
    end
    stream(1, 1'b0, 0, 64, rdy, cyc);
    check_done("reload100_done");
    sweep(1, "reload100");
  endtask

  task automatic test_toggle;
    int rdy, cyc;
    pulse_reload(1'b0);
    stream(2, 1'b1, 0, 64, rdy, cyc);
    total++;
    if (cyc != 127) begin
      bad++;
      $display("FAIL toggle_cycles got=%0d want=127", cyc);
    end
    check_done("toggle_done");
    sweep(2, "toggle");
  endtask

  task automatic test_reload_in_load;
    int rdy, cyc;
    pulse_reload(1'b0);
    stream(1, 1'b0, 0, 5, rdy, cyc);
    pulse_reload(1'b1);
    stream(0, 1'b0, 0, 64, rdy, cyc);
    check_done("reload_in_load_done");
    sweep(0, "reload_in_load");
  endtask

  task automatic test_rst_midload;
    int rdy, cyc;
    pulse_reload(1'b0);
    stream(1, 1'b0, 0, 30, rdy, cyc);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++;
    if (ready0 !== 1'b1 || done0 !== 1'b0 || cost1 !== 7'd0) begin
      bad++;
      $display("FAIL rst_midload ready=%b done=%b cost1=%0d want 1/0/0", ready0, done0, cost1);
    end
    stream(2, 1'b0, 0, 64, rdy, cyc);
    check_done("rst_midload_done");
    sweep(2, "rst_midload");
  endtask

`ifdef JAM_COST_ACCESS_CNT_EN
  task automatic test_rd_count;
    logic [15:0] c0;
    logic [5:0]  ad;
    @(negedge CLK); W = 3'd7; J = 3'd7;
    @(negedge CLK);
    c0 = cnt0;
    for (int n = 0; n < 64; n++) begin
      @(negedge CLK);
      ad = 6'(n);
      W  = ad[5:3];
      J  = ad[2:0];
    end
    @(negedge CLK);
    total++;
    if (cnt0 !== c0 + 16'd64) begin
      bad++;
      $display("FAIL count_sweep got=%0d want=%0d", cnt0, c0 + 16'd64);
    end
    repeat (5) @(negedge CLK);
    total++;
    if (cnt0 !== c0 + 16'd64) begin
      bad++;
      $display("FAIL count_hold got=%0d want=%0d", cnt0, c0 + 16'd64);
    end
    pulse_reload(1'b0);
    total++;
    if (cnt0 !== 16'd0) begin
      bad++;
      $display("FAIL count_reload got=%0d want=0", cnt0);
    end
    $display("rd_count sweep base=%0d after_reload=%0d", c0, cnt0);
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    sweep(0, "ramp");
    test_lookup_during_load;
    test_reload_same_cycle;
    test_toggle;
    test_reload_in_load;
    test_rst_midload;
`ifdef JAM_COST_ACCESS_CNT_EN
    test_rd_count;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
